// File: rtl/pkg_en.sv
// ElectronNest token types shared by the fabric boundary: forward data token and backward flow-control token.
package pkg_en;

    localparam int unsigned WIDTH_DATA  = 32;
    localparam int unsigned WIDTH_INDEX = 32;

    typedef struct packed {
        logic                   v;
        logic                   a;
        logic                   r;
        logic                   c;
        logic [WIDTH_INDEX-1:0] i;
        logic [WIDTH_DATA-1:0]  d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

endpackage

// File: rtl/electron_nest.sv
// Boot-configured load/store engine: bulk-loads external memory into a BRAM, then streams a BRAM window back out.
// Optional feature macro: EXTEND_MEM_EN (index-addressed load writes, store token index = store address).
module electron_nest #(
    parameter int unsigned WIDTH_DATA   = 32,
    parameter int unsigned WIDTH_EXADDR = 32,
    parameter int unsigned WIDTH_INDEX  = 32,
    parameter int unsigned BRAM_DEPTH   = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  pkg_en::FTk_t            I_Ld_FTk,
    output pkg_en::BTk_t            O_Ld_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output pkg_en::FTk_t            O_St_FTk,
    input  pkg_en::BTk_t            I_St_BTk
);

    localparam int unsigned AW = $clog2(BRAM_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {IDLE, BOOT, LOAD, DRAIN, STORE, DONE} state_t;

    state_t                  state, state_next;
    logic [2:0]              frame_cnt, frame_cnt_next;
    logic [WIDTH_EXADDR-1:0] ld_base, ld_base_next;
    logic [WIDTH_EXADDR-1:0] st_base, st_base_next;
    logic [AW-1:0]           rd_off, rd_off_next;
    logic [LW-1:0]           ld_len, ld_len_next;
    logic [LW-1:0]           st_len, st_len_next;
    logic [LW-1:0]           req_cnt, req_cnt_next;
    logic [LW-1:0]           rcv_cnt, rcv_cnt_next;
    logic [LW-1:0]           rd_cnt, rd_cnt_next;
    logic [LW-1:0]           acc_cnt, acc_cnt_next;
    logic                    ld_req, ld_req_next;
    logic [WIDTH_EXADDR-1:0] ld_addr, ld_addr_next;
    logic                    st_req, st_req_next;
    logic [WIDTH_EXADDR-1:0] st_addr, st_addr_next;
    pkg_en::FTk_t            st_ftk, st_ftk_next;

    logic [WIDTH_DATA-1:0]   mem [BRAM_DEPTH];
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_idx;
    logic                    rd_en;
    logic                    accept;
    logic                    boot_start;
    logic                    frame_word;
    logic [WIDTH_EXADDR-1:0] st_addr_calc;
    logic                    unused_bits;

    function automatic logic [LW-1:0] clamp_len(input logic [WIDTH_DATA-1:0] x);
        return (x > WIDTH_DATA'(BRAM_DEPTH)) ? LW'(BRAM_DEPTH) : LW'(x);
    endfunction

    assign boot_start = I_Boot && I_Ld_FTk.v && I_Ld_FTk.a;
    assign frame_word = I_Boot && I_Ld_FTk.v;

    // Load data capture: every valid word while loading is a return, bounded by ld_len.
    assign wr_en = ((state == LOAD) || (state == DRAIN)) && I_Ld_FTk.v && (rcv_cnt < ld_len);
`ifdef EXTEND_MEM_EN
    assign wr_addr     = AW'(I_Ld_FTk.i - WIDTH_INDEX'(ld_base));
    assign unused_bits = ^{I_Ld_FTk.r, I_Ld_FTk.c, I_St_BTk.t, I_St_BTk.v, I_St_BTk.c};
`else
    assign wr_addr     = AW'(rcv_cnt);
    assign unused_bits = ^{I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i, I_St_BTk.t, I_St_BTk.v, I_St_BTk.c};
`endif

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= I_Ld_FTk.d;
        end
    end

    // Stores may only advance when the output beat is empty or being taken this cycle.
    assign accept       = st_req && !I_St_BTk.n;
    assign rd_en        = (state == STORE) && (rd_cnt < st_len) && (!st_req || !I_St_BTk.n);
    assign rd_idx       = rd_off + AW'(rd_cnt);
    assign st_addr_calc = st_base + WIDTH_EXADDR'(rd_cnt);

    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        ld_base_next   = ld_base;
        st_base_next   = st_base;
        rd_off_next    = rd_off;
        ld_len_next    = ld_len;
        st_len_next    = st_len;
        req_cnt_next   = req_cnt;
        rcv_cnt_next   = rcv_cnt + LW'(wr_en);
        rd_cnt_next    = rd_cnt;
        acc_cnt_next   = acc_cnt;
        ld_req_next    = 1'b0;
        ld_addr_next   = ld_addr;
        st_req_next    = st_req;
        st_addr_next   = st_addr;
        st_ftk_next    = st_ftk;

        case (state)
            IDLE, DONE: begin
                if (boot_start) begin
                    state_next     = BOOT;
                    frame_cnt_next = 3'd1;
                    req_cnt_next   = '0;
                    rcv_cnt_next   = '0;
                    rd_cnt_next    = '0;
                    acc_cnt_next   = '0;
                end
            end
            BOOT: begin
                if (frame_word) begin
                    frame_cnt_next = frame_cnt + 3'd1;
                    case (frame_cnt)
                        3'd3: ld_base_next = WIDTH_EXADDR'(I_Ld_FTk.d);
                        3'd4: ld_len_next  = clamp_len(I_Ld_FTk.d);
                        3'd5: st_base_next = WIDTH_EXADDR'(I_Ld_FTk.d);
                        3'd6: rd_off_next  = AW'(I_Ld_FTk.d);
                        3'd7: begin
                            st_len_next = clamp_len(I_Ld_FTk.d);
                            state_next  = (ld_len == '0) ? STORE : LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                ld_req_next  = 1'b1;
                ld_addr_next = ld_base + WIDTH_EXADDR'(req_cnt);
                req_cnt_next = req_cnt + LW'(1);
                if (req_cnt_next == ld_len) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (rcv_cnt == ld_len) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                if (accept) begin
                    acc_cnt_next = acc_cnt + LW'(1);
                end
                if (rd_en) begin
                    st_req_next   = 1'b1;
                    st_addr_next  = st_addr_calc;
                    st_ftk_next   = '0;
                    st_ftk_next.v = 1'b1;
                    st_ftk_next.d = mem[rd_idx];
`ifdef EXTEND_MEM_EN
                    st_ftk_next.i = WIDTH_INDEX'(st_addr_calc);
`else
                    st_ftk_next.i = WIDTH_INDEX'(0);
`endif
                    rd_cnt_next   = rd_cnt + LW'(1);
                end else if (accept) begin
                    st_req_next  = 1'b0;
                    st_addr_next = '0;
                    st_ftk_next  = '0;
                end
                if ((st_len == '0) || (acc_cnt_next == st_len)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            ld_base   <= '0;
            st_base   <= '0;
            rd_off    <= '0;
            ld_len    <= '0;
            st_len    <= '0;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            rd_cnt    <= '0;
            acc_cnt   <= '0;
            ld_req    <= 1'b0;
            ld_addr   <= '0;
            st_req    <= 1'b0;
            st_addr   <= '0;
            st_ftk    <= '0;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
            ld_base   <= ld_base_next;
            st_base   <= st_base_next;
            rd_off    <= rd_off_next;
            ld_len    <= ld_len_next;
            st_len    <= st_len_next;
            req_cnt   <= req_cnt_next;
            rcv_cnt   <= rcv_cnt_next;
            rd_cnt    <= rd_cnt_next;
            acc_cnt   <= acc_cnt_next;
            ld_req    <= ld_req_next;
            ld_addr   <= ld_addr_next;
            st_req    <= st_req_next;
            st_addr   <= st_addr_next;
            st_ftk    <= st_ftk_next;
        end
    end

    assign O_Ld_Req  = ld_req;
    assign O_Ld_Addr = ld_addr;
    assign O_Ld_BTk  = '0;
    assign O_St_Req  = st_req;
    assign O_St_Addr = st_addr;
    assign O_St_FTk  = st_ftk;

endmodule

// File: tb/tb_electron_nest.sv
// Directed bench for electron_nest: external memory responder/sink model plus per-scenario checking tasks.
module tb_electron_nest;

    logic         clock = 1'b0;
    logic         reset;
    logic         I_Boot;
    logic         O_Ld_Req;
    logic [31:0]  O_Ld_Addr;
    pkg_en::FTk_t I_Ld_FTk;
    pkg_en::BTk_t O_Ld_BTk;
    logic         O_St_Req;
    logic [31:0]  O_St_Addr;
    pkg_en::FTk_t O_St_FTk;
    pkg_en::BTk_t I_St_BTk;

    pkg_en::FTk_t boot_ftk, ret_ftk, pend;
    logic         boot_mode;
    assign I_Ld_FTk = boot_mode ? boot_ftk : ret_ftk;

    electron_nest dut (
        .clock     (clock),
        .reset     (reset),
        .I_Boot    (I_Boot),
        .O_Ld_Req  (O_Ld_Req),
        .O_Ld_Addr (O_Ld_Addr),
        .I_Ld_FTk  (I_Ld_FTk),
        .O_Ld_BTk  (O_Ld_BTk),
        .O_St_Req  (O_St_Req),
        .O_St_Addr (O_St_Addr),
        .O_St_FTk  (O_St_FTk),
        .I_St_BTk  (I_St_BTk)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] VA = 32'hA000_0001;
    localparam logic [31:0] VB = 32'hB000_0002;
    localparam logic [31:0] VC = 32'hC000_0003;
    localparam logic [31:0] VD = 32'hD000_0004;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] xmem [256];
    logic [31:0] frame [8];
    int          ld_reqs, st_beats, stall_beat, stall_left, stall_seen;
    logic [31:0] ld_first, ld_last, held_d, held_a;
    logic        held_bad, tok_bad;

    // External memory: loads answer one cycle after the request, stores land when n=0.
    always @(negedge clock) begin
        ret_ftk = pend;
        pend    = '0;
        if (O_Ld_Req) begin
            if (ld_reqs == 0) ld_first = O_Ld_Addr;
            ld_last = O_Ld_Addr;
            ld_reqs++;
            pend.v = 1'b1;
            pend.d = xmem[O_Ld_Addr[7:0]];
            pend.i = O_Ld_Addr;
        end
        I_St_BTk = '0;
        if (O_St_Req) begin
            if (!O_St_FTk.v || O_St_FTk.a || O_St_FTk.r || O_St_FTk.c) tok_bad = 1'b1;
`ifdef EXTEND_MEM_EN
            if (O_St_FTk.i !== O_St_Addr) tok_bad = 1'b1;
`else
            if (O_St_FTk.i !== 32'h0) tok_bad = 1'b1;
`endif
            if (st_beats == stall_beat && stall_seen > 0 &&
                (O_St_FTk.d !== held_d || O_St_Addr !== held_a)) held_bad = 1'b1;
            if (st_beats == stall_beat && stall_left > 0) begin
                held_d = O_St_FTk.d;
                held_a = O_St_Addr;
                stall_seen++;
                stall_left--;
                I_St_BTk.n = 1'b1;
            end else begin
                xmem[O_St_Addr[7:0]] = O_St_FTk.d;
                st_beats++;
            end
        end
    end

    task automatic clear_log();
        ld_reqs = 0; st_beats = 0; stall_beat = -1; stall_left = 0; stall_seen = 0;
        ld_first = '0; ld_last = '0; held_bad = 1'b0; tok_bad = 1'b0;
    endtask

    // Eight-word frame with a v=0 bubble before word 5; only word 0 may carry a=1.
    task automatic send_frame(input bit use_a);
        @(negedge clock);
        boot_mode = 1'b1;
        I_Boot    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                boot_ftk = '0;
                @(negedge clock);
            end
            boot_ftk   = '0;
            boot_ftk.v = 1'b1;
            boot_ftk.a = use_a && (k == 0);
            boot_ftk.d = frame[k];
            @(negedge clock);
        end
        boot_ftk  = '0;
        I_Boot    = 1'b0;
        boot_mode = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int c = 0;
        while (st_beats < n && c < budget) begin
            @(posedge clock);
            c++;
        end
        ok = (st_beats >= n);
        repeat (10) @(posedge clock);
    endtask

    task automatic preload_basic();
        xmem[8'h10] = VA; xmem[8'h11] = VB; xmem[8'h12] = VC; xmem[8'h13] = VD;
        for (int k = 8'h40; k < 8'h44; k++) xmem[k] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (O_Ld_Req !== 1'b0 || O_Ld_Addr !== 32'h0) begin fails++; $display("FAIL reset_ld got %b/%h want 0/0", O_Ld_Req, O_Ld_Addr); end
        checks++; if (O_St_Req !== 1'b0 || O_St_Addr !== 32'h0) begin fails++; $display("FAIL reset_st got %b/%h want 0/0", O_St_Req, O_St_Addr); end
        checks++; if (O_St_FTk !== '0) begin fails++; $display("FAIL reset_st_ftk got %h want 0", O_St_FTk); end
        checks++; if (O_Ld_BTk !== '0) begin fails++; $display("FAIL reset_ld_btk got %h want 0", O_Ld_BTk); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_no_start();
        bit ok;
        clear_log();
        preload_basic();
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h4, 32'h40, 32'h0, 32'h4};
        send_frame(1'b0);
        wait_beats(0, 30, ok);
        repeat (20) @(posedge clock);
        checks++; if (ld_reqs !== 0) begin fails++; $display("FAIL no_start_ld got %0d want 0", ld_reqs); end
        checks++; if (st_beats !== 0) begin fails++; $display("FAIL no_start_st got %0d want 0", st_beats); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_log();
        preload_basic();
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h4, 32'h40, 32'h0, 32'h4};
        send_frame(1'b1);
        wait_beats(4, 100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL basic_timeout got %0d beats want 4", st_beats); end
        checks++; if (ld_reqs !== 4) begin fails++; $display("FAIL basic_ld_reqs got %0d want 4", ld_reqs); end
        checks++; if (ld_first !== 32'h10 || ld_last !== 32'h13) begin fails++; $display("FAIL basic_ld_addr got %h..%h want 10..13", ld_first, ld_last); end
        checks++; if (xmem[8'h40] !== VA || xmem[8'h41] !== VB) begin fails++; $display("FAIL basic_st01 got %h %h want %h %h", xmem[8'h40], xmem[8'h41], VA, VB); end
        checks++; if (xmem[8'h42] !== VC || xmem[8'h43] !== VD) begin fails++; $display("FAIL basic_st23 got %h %h want %h %h", xmem[8'h42], xmem[8'h43], VC, VD); end
        checks++; if (st_beats !== 4 || O_St_Req !== 1'b0) begin fails++; $display("FAIL basic_done got %0d/%b want 4/0", st_beats, O_St_Req); end
        checks++; if (tok_bad !== 1'b0) begin fails++; $display("FAIL basic_token got %b want 0", tok_bad); end
    endtask

    task automatic test_rd_off();
        bit ok;
        clear_log();
        preload_basic();
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h4, 32'h40, 32'h2, 32'h2};
        send_frame(1'b1);
        wait_beats(2, 100, ok);
        checks++; if (!ok || st_beats !== 2) begin fails++; $display("FAIL rdoff_beats got %0d want 2", st_beats); end
        checks++; if (xmem[8'h40] !== VC || xmem[8'h41] !== VD) begin fails++; $display("FAIL rdoff_data got %h %h want %h %h", xmem[8'h40], xmem[8'h41], VC, VD); end
        checks++; if (xmem[8'h42] !== 32'h0 || xmem[8'h43] !== 32'h0) begin fails++; $display("FAIL rdoff_extra got %h %h want 0 0", xmem[8'h42], xmem[8'h43]); end
    endtask

    task automatic test_back_to_back_stall();
        bit ok;
        clear_log();
        preload_basic();
        stall_beat = 1;
        stall_left = 3;
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h4, 32'h40, 32'h0, 32'h4};
        send_frame(1'b1);
        wait_beats(4, 100, ok);
        checks++; if (!ok || st_beats !== 4) begin fails++; $display("FAIL stall_beats got %0d want 4", st_beats); end
        checks++; if (stall_seen !== 3 || held_bad !== 1'b0) begin fails++; $display("FAIL stall_hold got %0d/%b want 3/0", stall_seen, held_bad); end
        checks++; if (xmem[8'h40] !== VA || xmem[8'h41] !== VB || xmem[8'h42] !== VC || xmem[8'h43] !== VD) begin
            fails++; $display("FAIL stall_data got %h %h %h %h", xmem[8'h40], xmem[8'h41], xmem[8'h42], xmem[8'h43]); end
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_log();
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h0, 32'h40, 32'h0, 32'h0};
        send_frame(1'b1);
        wait_beats(0, 10, ok);
        repeat (20) @(posedge clock);
        checks++; if (ld_reqs !== 0 || st_beats !== 0) begin fails++; $display("FAIL zero_len got %0d/%0d want 0/0", ld_reqs, st_beats); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_log();
        xmem[8'hFE] = 32'hE000_0000; xmem[8'hFF] = 32'hE000_0001;
        xmem[8'h00] = 32'hE000_0002; xmem[8'h01] = 32'hE000_0003;
        frame = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h4, 32'h80, 32'h0, 32'h4};
        send_frame(1'b1);
        wait_beats(4, 100, ok);
        checks++; if (ld_first !== 32'hFFFF_FFFE || ld_last !== 32'h1) begin fails++; $display("FAIL wrap_addr got %h..%h want fffffffe..1", ld_first, ld_last); end
        checks++; if (xmem[8'h80] !== 32'hE000_0000 || xmem[8'h83] !== 32'hE000_0003) begin fails++; $display("FAIL wrap_data got %h %h want e0000000 e0000003", xmem[8'h80], xmem[8'h83]); end
    endtask

    task automatic test_clamp();
        bit ok;
        clear_log();
        xmem[8'h10] = VA; xmem[8'h11] = VB;
        frame = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1000, 32'h90, 32'h10, 32'h2};
        send_frame(1'b1);
        wait_beats(2, 400, ok);
        checks++; if (ld_reqs !== 256 || ld_last !== 32'hFF) begin fails++; $display("FAIL clamp_ld got %0d/%h want 256/ff", ld_reqs, ld_last); end
        checks++; if (!ok || xmem[8'h90] !== VA || xmem[8'h91] !== VB) begin fails++; $display("FAIL clamp_st got %h %h want %h %h", xmem[8'h90], xmem[8'h91], VA, VB); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c = 0;
        clear_log();
        preload_basic();
        frame = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h4, 32'h40, 32'h0, 32'h4};
        send_frame(1'b1);
        while (!O_St_Req && c < 100) begin @(negedge clock); c++; end
        checks++; if (O_St_Req !== 1'b1) begin fails++; $display("FAIL midrst_reach got %b want 1", O_St_Req); end
        reset = 1'b0;
        #1;
        checks++; if (O_St_Req !== 1'b0 || O_St_Addr !== 32'h0 || O_St_FTk !== '0) begin
            fails++; $display("FAIL midrst_clear got %b/%h/%h want 0/0/0", O_St_Req, O_St_Addr, O_St_FTk); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        clear_log();
        preload_basic();
        send_frame(1'b1);
        wait_beats(4, 100, ok);
        checks++; if (!ok || ld_reqs !== 4 || st_beats !== 4) begin fails++; $display("FAIL midrst_reboot got %0d/%0d want 4/4", ld_reqs, st_beats); end
        checks++; if (xmem[8'h40] !== VA || xmem[8'h43] !== VD) begin fails++; $display("FAIL midrst_data got %h %h want %h %h", xmem[8'h40], xmem[8'h43], VA, VD); end
    endtask

    initial begin
        I_Boot = 1'b0; boot_mode = 1'b0; boot_ftk = '0; ret_ftk = '0; pend = '0; I_St_BTk = '0;
        for (int k = 0; k < 256; k++) xmem[k] = '0;
        clear_log();
        test_reset();
        test_no_start();
        test_basic();
        test_rd_off();
        test_back_to_back_stall();
        test_zero_len();
        test_wrap();
        test_clamp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
